// File: rtl/fetch_unit.sv
// Instruction-fetch stage: holds the PC, reads a variable-latency instruction memory,
// buffers one word for decode, and applies redirects, HALT and memory faults.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_rd,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        imem_done,
  input  logic        imem_err,
  input  logic        stall_in,
  input  logic        halt_in,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [15:0] instr,
  output logic [4:0]  opcode,
  output logic [1:0]  funct,
  output logic [15:0] pc_plus2,
  output logic        instr_valid,
  output logic        halted,
  output logic        err
);
  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_DRAIN, S_HALT} state_t;

  state_t      r_state, w_next;
  logic [15:0] r_pc, r_req_addr, r_instr, r_pc_plus2;
  logic        r_valid, r_halted, r_err;
  logic        w_consume, w_free, w_issue, w_accept, w_load, w_fault;
  logic        w_halt_take, w_bad_target;

  // A request only leaves FETCH when the output register is free, so a word
  // returning in WAIT always lands in an empty register and no skid is needed.
  assign w_consume    = r_valid & ~stall_in;
  assign w_free       = ~r_valid | (w_consume & ~halt_in);
  assign w_issue      = (r_state == S_FETCH) & w_free & ~redirect & ~r_halted;
  assign w_accept     = ~redirect & imem_done & (w_issue | (r_state == S_WAIT));
  assign w_load       = w_accept & ~imem_err;
  assign w_fault      = w_accept & imem_err;
  assign w_halt_take  = (r_state == S_FETCH) & ~redirect & w_consume & halt_in;
  assign w_bad_target = redirect & redirect_pc[0];

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH: begin
        if (w_bad_target | w_fault | w_halt_take) w_next = S_HALT;
        else if (w_issue & ~imem_done)            w_next = S_WAIT;
      end
      S_WAIT: begin
        if (w_bad_target | w_fault)      w_next = S_HALT;
        else if (redirect & ~imem_done)  w_next = S_DRAIN;
        else if (imem_done)              w_next = S_FETCH;
      end
      S_DRAIN: begin
        if (w_bad_target)   w_next = S_HALT;
        else if (imem_done) w_next = S_FETCH;
      end
      default: w_next = S_HALT;
    endcase
  end

  // The address of an outstanding request is kept apart from the PC so a
  // redirect can retarget the PC while the abandoned read drains.
  always_comb begin
    imem_rd   = 1'b0;
    imem_addr = r_pc;
    case (r_state)
      S_FETCH: imem_rd = w_issue;
      S_WAIT, S_DRAIN: begin
        imem_rd   = 1'b1;
        imem_addr = r_req_addr;
      end
      default: imem_rd = 1'b0;
    endcase
    if (rst) imem_rd = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_req_addr <= RESET_PC;
      r_instr    <= 16'h0800;
      r_pc_plus2 <= RESET_PC + 16'd2;
      r_valid    <= 1'b0;
      r_halted   <= 1'b0;
      r_err      <= 1'b0;
    end else if (r_state != S_HALT) begin
      if (w_issue) r_req_addr <= r_pc;
      if (redirect) begin
        r_pc    <= redirect_pc;
        r_valid <= 1'b0;
        if (redirect_pc[0]) begin
          r_err    <= 1'b1;
          r_halted <= 1'b1;
        end
      end else if (w_fault) begin
        r_err    <= 1'b1;
        r_halted <= 1'b1;
        r_valid  <= 1'b0;
      end else if (w_load) begin
        r_instr    <= imem_data;
        r_pc_plus2 <= r_pc + 16'd2;
        r_pc       <= r_pc + 16'd2;
        r_valid    <= 1'b1;
      end else if (w_halt_take) begin
        r_valid  <= 1'b0;
        r_halted <= 1'b1;
      end else if (w_consume) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign instr       = r_instr;
  assign opcode      = r_instr[15:11];
  assign funct       = r_instr[1:0];
  assign pc_plus2    = r_pc_plus2;
  assign instr_valid = r_valid;
  assign halted      = r_halted;
  assign err         = r_err;
endmodule
